// File: rtl/dac_spi_driver_pkg.sv
// Shared definitions for the serial DAC driver: FSM state encodings,
// frame-width helpers and the DAC control-field constant.
package dac_spi_driver_pkg;

  // Driver states; values are fixed so waveform dumps read consistently.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } dacState_e;

  // Control nibble telling the DAC to write the input register and update
  // the output in one frame.
  localparam logic [3:0] CTRL_WRITE_UPDATE = 4'b0000;

  // A frame is the control field followed by the data word.
  function automatic int frameWidth(input int ctrlW, input int dataW);
    return ctrlW + dataW;
  endfunction

  // Counter width for a modulus, never narrower than one bit.
  function automatic int widthOf(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// Half-period divider for the SPI clock. Counts 0..CLK_DIV-1 while the
// driver is busy and flags the last cycle of each sclk half-period.
module dac_sclk_div
  import dac_spi_driver_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_syncClr,
  output logic o_halfEnd
);

  localparam int DIV_W = widthOf(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_divCnt;

  // Divider restarts at zero on every state entry so each half-period is aligned to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divCnt <= '0;
    end else if (i_syncClr || !i_run) begin
      r_divCnt <= '0;
    end else if (r_divCnt == DIV_LAST) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + DIV_W'(1);
    end
  end

  assign o_halfEnd = i_run && (r_divCnt == DIV_LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// Serial DAC driver: samples the waveform word at a fixed rate and shifts
// it out MSB first as a control+data SPI frame (CPOL=0, DAC samples on the
// rising sclk edge). Reports busy, a frame-done pulse and sticky overrun.
module dac_spi_driver
  import dac_spi_driver_pkg::*;
#(
  parameter int                DATA_W     = 12,
  parameter int                CTRL_W     = 4,
  parameter logic [CTRL_W-1:0] CTRL_BITS  = CTRL_W'(CTRL_WRITE_UPDATE),
  parameter int                CLK_DIV    = 2,
  parameter int                SAMPLE_DIV = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdo,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int FRAME_W = frameWidth(CTRL_W, DATA_W);
  localparam int BIT_W   = widthOf(FRAME_W);
  localparam int SAMP_W  = widthOf(SAMPLE_DIV);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  logic [SAMP_W-1:0]  r_sampCnt;
  logic               w_tick;

  dacState_e          r_state;
  dacState_e          w_nextState;
  logic [FRAME_W-1:0] r_shreg;
  logic [FRAME_W-1:0] w_nextShreg;
  logic [BIT_W-1:0]   r_bitCnt;
  logic [BIT_W-1:0]   w_nextBitCnt;
  logic               r_csN;
  logic               w_nextCsN;
  logic               r_sclk;
  logic               w_nextSclk;
  logic               r_sdo;
  logic               w_nextSdo;
  logic               r_frameDone;
  logic               w_nextFrameDone;
  logic               r_overrun;

  logic [FRAME_W-1:0] w_loadFrame;
  logic               w_busy;
  logic               w_halfEnd;
  logic               w_divClr;

  assign w_loadFrame = {CTRL_BITS, din};
  assign w_busy      = (r_state != IDLE);
  assign w_tick      = (r_sampCnt == SAMP_LAST) && en;
  assign w_divClr    = (w_nextState != r_state);

  // Sample timer: free-running modulo SAMPLE_DIV while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sampCnt <= '0;
    end else if (!en) begin
      r_sampCnt <= '0;
    end else if (r_sampCnt == SAMP_LAST) begin
      r_sampCnt <= '0;
    end else begin
      r_sampCnt <= r_sampCnt + SAMP_W'(1);
    end
  end

  dac_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclkDiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_busy),
    .i_syncClr(w_divClr),
    .o_halfEnd(w_halfEnd)
  );

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_nextState     = r_state;
    w_nextShreg     = r_shreg;
    w_nextBitCnt    = r_bitCnt;
    w_nextCsN       = r_csN;
    w_nextSclk      = r_sclk;
    w_nextSdo       = r_sdo;
    w_nextFrameDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_nextState  = SHIFT;
          w_nextShreg  = w_loadFrame;
          w_nextBitCnt = BIT_LAST;
          w_nextCsN    = 1'b0;
          w_nextSclk   = 1'b0;
          w_nextSdo    = w_loadFrame[FRAME_W-1];
        end
      end
      SHIFT: begin
        if (w_halfEnd) begin
          if (!r_sclk) begin
            w_nextSclk = 1'b1;
          end else begin
            w_nextSclk = 1'b0;
            if (r_bitCnt != '0) begin
              w_nextShreg  = {r_shreg[FRAME_W-2:0], 1'b0};
              w_nextSdo    = r_shreg[FRAME_W-2];
              w_nextBitCnt = r_bitCnt - BIT_W'(1);
            end else begin
              w_nextCsN   = 1'b1;
              w_nextSdo   = 1'b0;
              w_nextState = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (w_halfEnd) begin
          w_nextState     = IDLE;
          w_nextFrameDone = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCsN   = 1'b1;
        w_nextSclk  = 1'b0;
        w_nextSdo   = 1'b0;
      end
    endcase
  end

  // Frame sequencer registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bitCnt    <= '0;
      r_csN       <= 1'b1;
      r_sclk      <= 1'b0;
      r_sdo       <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_shreg     <= w_nextShreg;
      r_bitCnt    <= w_nextBitCnt;
      r_csN       <= w_nextCsN;
      r_sclk      <= w_nextSclk;
      r_sdo       <= w_nextSdo;
      r_frameDone <= w_nextFrameDone;
    end
  end

  // Overrun latches the first sample tick that arrives while a frame is still going.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_tick && w_busy) begin
      r_overrun <= 1'b1;
    end
  end

  assign cs_n       = r_csN;
  assign sclk       = r_sclk;
  assign sdo        = r_sdo;
  assign busy       = w_busy;
  assign frame_done = r_frameDone;
  assign overrun    = r_overrun;

endmodule
